// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Holds the state encoding and the default bit timing and parity settings.
package fifo_uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
  localparam bit          DEFAULT_PARITY_EN    = 1'b0;
  localparam int unsigned CNT_W                = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled.
// Ticks on the last count and restarts from zero when cleared.
module baud_counter
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The tick must not depend on clear_i: the clear is derived from the tick.
  assign tick_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a FIFO read port and sends 8N1
// frames, with an optional even-parity bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit          PARITY_EN    = DEFAULT_PARITY_EN
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic [7:0] i_fifo_data,
  input  logic       i_fifo_empty,
  output logic       o_fifo_rd,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        tick;
  logic        cnt_clear;
  logic        cnt_enable;

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_counter (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .clear_i (cnt_clear),
    .enable_i(cnt_enable),
    .tick_o  (tick)
  );

  // Gated by reset so no pop is requested while reset is held.
  assign o_fifo_rd = i_reset_n && (state_q == ST_IDLE) && i_enable && !i_fifo_empty;

  // The shift register rotates, so after eight data bits it again holds the original byte.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (o_fifo_rd) begin
          shift_d = i_fifo_data;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {shift_q[0], shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = even_parity(shift_d);
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

  assign cnt_clear  = (state_d != state_q);
  assign cnt_enable = (state_q != ST_IDLE);

  assign o_tx   = tx_q;
  assign o_busy = (state_q != ST_IDLE);
  assign o_done = (state_q == ST_STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4: one instance without
// parity fed from a small FIFO model, one with parity fed a single byte.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;

  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd, tx, busy, done;

  logic [7:0] p_data = 8'h00;
  logic [3:0] p_pushes = 4'd0;
  logic [3:0] p_pops = 4'd0;
  logic       p_empty;
  logic       p_rd, p_tx, p_busy, p_done;

  int checks = 0;
  int fails = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr];
  assign p_empty    = (p_pushes == p_pops);

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_enable    (enable),
    .i_fifo_data (fifo_data),
    .i_fifo_empty(fifo_empty),
    .o_fifo_rd   (fifo_rd),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_done      (done)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut_par (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_enable    (enable),
    .i_fifo_data (p_data),
    .i_fifo_empty(p_empty),
    .o_fifo_rd   (p_rd),
    .o_tx        (p_tx),
    .o_busy      (p_busy),
    .o_done      (p_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd) rd_ptr <= rd_ptr + 4'd1;
    if (p_rd) p_pops <= p_pops + 4'd1;
  end

  // Expected line level in cycle k (1-based) after the pop cycle.
  function automatic logic exp_tx(input logic [7:0] b, input bit par, input int k);
    int slot;
    slot = (k - 1) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (par && slot == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic test_reset();
    logic [3:0] r0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    push(8'h5A);
    p_data = 8'h5A;
    p_pushes = p_pushes + 4'd1;
    r0 = rd_ptr;
    #1;
    checks++; if (tx !== 1'b1) begin fails++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (fifo_rd !== 1'b0) begin fails++; $display("[TB] FAIL reset_rd: got %b expected 0", fifo_rd); end
    checks++; if (p_tx !== 1'b1) begin fails++; $display("[TB] FAIL reset_p_tx: got %b expected 1", p_tx); end
    checks++; if (p_rd !== 1'b0) begin fails++; $display("[TB] FAIL reset_p_rd: got %b expected 0", p_rd); end
    @(negedge clk);
    checks++; if (rd_ptr !== r0) begin fails++; $display("[TB] FAIL reset_no_pop: got ptr %0d expected %0d", rd_ptr, r0); end
    wr_ptr = rd_ptr;
    p_pushes = p_pops;
    reset_n = 1'b1;
    #1;
    checks++; if (fifo_rd !== 1'b0) begin fails++; $display("[TB] FAIL release_rd_empty: got %b expected 0", fifo_rd); end
  endtask

  task automatic test_single_a5();
    logic [9:0]  bits;
    logic [10:0] pbits;
    logic [3:0]  r0;
    bits  = 10'b1101001010;
    pbits = 11'b10101001010;
    @(negedge clk);
    push(8'hA5);
    p_data = 8'hA5;
    p_pushes = p_pushes + 4'd1;
    r0 = rd_ptr;
    #1;
    checks++; if (fifo_rd !== 1'b1) begin fails++; $display("[TB] FAIL a5_pop: got %b expected 1", fifo_rd); end
    checks++; if (p_rd !== 1'b1) begin fails++; $display("[TB] FAIL a5_p_pop: got %b expected 1", p_rd); end
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (k <= 40) begin
        checks++; if (tx !== bits[(k-1)/CPB]) begin fails++; $display("[TB] FAIL a5_tx c%0d: got %b expected %b", k, tx, bits[(k-1)/CPB]); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL a5_busy c%0d: got %b expected 1", k, busy); end
        checks++; if (done !== (k == 40)) begin fails++; $display("[TB] FAIL a5_done c%0d: got %b expected %b", k, done, (k == 40)); end
      end else begin
        checks++; if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL a5_idle c%0d: got tx=%b busy=%b done=%b expected 1/0/0", k, tx, busy, done); end
      end
      checks++; if (fifo_rd !== 1'b0) begin fails++; $display("[TB] FAIL a5_extra_pop c%0d: got %b expected 0", k, fifo_rd); end
      checks++; if (p_tx !== pbits[(k-1)/CPB]) begin fails++; $display("[TB] FAIL a5p_tx c%0d: got %b expected %b", k, p_tx, pbits[(k-1)/CPB]); end
      checks++; if (p_busy !== 1'b1) begin fails++; $display("[TB] FAIL a5p_busy c%0d: got %b expected 1", k, p_busy); end
      checks++; if (p_done !== (k == 44)) begin fails++; $display("[TB] FAIL a5p_done c%0d: got %b expected %b", k, p_done, (k == 44)); end
    end
    checks++; if (rd_ptr !== r0 + 4'd1) begin fails++; $display("[TB] FAIL a5_pop_count: got ptr %0d expected %0d", rd_ptr, r0 + 4'd1); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] r0;
    logic [7:0] b;
    logic       e;
    int         kk;
    @(negedge clk);
    push(8'h00);
    push(8'hFF);
    r0 = rd_ptr;
    #1;
    checks++; if (fifo_rd !== 1'b1) begin fails++; $display("[TB] FAIL b2b_pop1: got %b expected 1", fifo_rd); end
    for (int k = 1; k <= 81; k++) begin
      @(negedge clk);
      if (k == 41) begin
        checks++; if (fifo_rd !== 1'b1) begin fails++; $display("[TB] FAIL b2b_pop2: got %b expected 1", fifo_rd); end
        checks++; if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL b2b_gap: got tx=%b busy=%b done=%b expected 1/0/0", tx, busy, done); end
      end else begin
        kk = (k <= 40) ? k : k - 41;
        b  = (k <= 40) ? 8'h00 : 8'hFF;
        e  = exp_tx(b, 1'b0, kk);
        checks++; if (tx !== e) begin fails++; $display("[TB] FAIL b2b_tx c%0d: got %b expected %b", k, tx, e); end
        checks++; if (done !== (kk == 40)) begin fails++; $display("[TB] FAIL b2b_done c%0d: got %b expected %b", k, done, (kk == 40)); end
        checks++; if (fifo_rd !== 1'b0 || busy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_rd_busy c%0d: got rd=%b busy=%b expected 0/1", k, fifo_rd, busy); end
      end
    end
    checks++; if (rd_ptr !== r0 + 4'd2) begin fails++; $display("[TB] FAIL b2b_pop_count: got ptr %0d expected %0d", rd_ptr, r0 + 4'd2); end
  endtask

  task automatic test_empty_idle();
    logic [3:0] r0;
    @(negedge clk);
    wr_ptr = rd_ptr;
    enable = 1'b1;
    r0 = rd_ptr;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++; if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL empty_idle c%0d: got rd=%b tx=%b busy=%b expected 0/1/0", k, fifo_rd, tx, busy); end
    end
    checks++; if (rd_ptr !== r0) begin fails++; $display("[TB] FAIL empty_no_pop: got ptr %0d expected %0d", rd_ptr, r0); end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] r0;
    logic       e;
    @(negedge clk);
    push(8'hC3);
    r0 = rd_ptr;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 10) push(8'h77);
    end
    checks++; if (tx !== 1'b0) begin fails++; $display("[TB] FAIL mid_bit3: got %b expected 0", tx); end
    reset_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin fails++; $display("[TB] FAIL mid_reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); end
    checks++; if (fifo_rd !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_rd: got %b expected 0", fifo_rd); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || fifo_rd !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_hold c%0d: got done=%b rd=%b busy=%b expected 0/0/0", k, done, fifo_rd, busy); end
    end
    checks++; if (rd_ptr !== r0 + 4'd1) begin fails++; $display("[TB] FAIL mid_no_pop: got ptr %0d expected %0d", rd_ptr, r0 + 4'd1); end
    reset_n = 1'b1;
    #1;
    checks++; if (fifo_rd !== 1'b1) begin fails++; $display("[TB] FAIL mid_release_pop: got %b expected 1", fifo_rd); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      e = exp_tx(8'h77, 1'b0, k);
      checks++; if (tx !== e || done !== (k == 40)) begin fails++; $display("[TB] FAIL mid_next c%0d: got tx=%b done=%b expected %b/%b", k, tx, done, e, (k == 40)); end
    end
    checks++; if (rd_ptr !== r0 + 4'd2) begin fails++; $display("[TB] FAIL mid_pop_count: got ptr %0d expected %0d", rd_ptr, r0 + 4'd2); end
  endtask

  task automatic test_enable_drop();
    logic [3:0] r0;
    logic       e;
    @(negedge clk);
    enable = 1'b1;
    push(8'h11);
    push(8'h22);
    r0 = rd_ptr;
    #1;
    checks++; if (fifo_rd !== 1'b1) begin fails++; $display("[TB] FAIL en_pop1: got %b expected 1", fifo_rd); end
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k <= 40) begin
        e = exp_tx(8'h11, 1'b0, k);
        checks++; if (tx !== e || done !== (k == 40)) begin fails++; $display("[TB] FAIL en_frame c%0d: got tx=%b done=%b expected %b/%b", k, tx, done, e, (k == 40)); end
      end else begin
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin fails++; $display("[TB] FAIL en_held c%0d: got busy=%b tx=%b expected 0/1", k, busy, tx); end
      end
      checks++; if (fifo_rd !== 1'b0) begin fails++; $display("[TB] FAIL en_blocked c%0d: got %b expected 0", k, fifo_rd); end
      if (k == 2) enable = 1'b0;
    end
    checks++; if (rd_ptr !== r0 + 4'd1) begin fails++; $display("[TB] FAIL en_pop_count1: got ptr %0d expected %0d", rd_ptr, r0 + 4'd1); end
    enable = 1'b1;
    #1;
    checks++; if (fifo_rd !== 1'b1) begin fails++; $display("[TB] FAIL en_pop2: got %b expected 1", fifo_rd); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      e = exp_tx(8'h22, 1'b0, k);
      checks++; if (tx !== e || done !== (k == 40)) begin fails++; $display("[TB] FAIL en_frame2 c%0d: got tx=%b done=%b expected %b/%b", k, tx, done, e, (k == 40)); end
    end
    checks++; if (rd_ptr !== r0 + 4'd2) begin fails++; $display("[TB] FAIL en_pop_count2: got ptr %0d expected %0d", rd_ptr, r0 + 4'd2); end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_empty_idle();
    test_reset_midframe();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter PARITY_EN, default 0, where 1 inserts an even-parity bit after the data bits.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_enable  input  1  permits starting a new frame.
REQ-006 i_fifo_data  input  8  FIFO read-port data, valid combinationally whenever i_fifo_empty=0.
REQ-007 i_fifo_empty  input  1  FIFO empty flag.
REQ-008 o_fifo_rd  output  1  one-cycle pop request to the FIFO read side.
REQ-009 o_tx  output  1  serial line, idle high.
REQ-010 o_busy  output  1  high whenever a frame is in progress.
REQ-011 o_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-012 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-013 In IDLE, o_fifo_rd SHALL be combinationally high exactly when i_enable=1 and i_fifo_empty=0, and SHALL be low in every other state.
REQ-014 On an edge where o_fifo_rd=1, the block SHALL load i_fifo_data into an 8-bit shift register and move to START.
REQ-015 START SHALL drive o_tx=0 for CLKS_PER_BIT cycles.
REQ-016 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index that wraps 7->0 on exit.
REQ-017 When PARITY_EN=1, the PARITY state SHALL drive the XOR of the 8 latched bits for CLKS_PER_BIT cycles; when PARITY_EN=0, PARITY SHALL never be entered.
REQ-018 STOP SHALL drive o_tx=1 for CLKS_PER_BIT cycles, pulse o_done on its final cycle, and then return to IDLE.
REQ-019 A frame SHALL therefore occupy 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-020 Back-to-back frames SHALL be separated by exactly one idle-high IDLE cycle, during which the next pop may occur.
REQ-021 o_tx SHALL be registered, and o_busy SHALL equal (state != IDLE).
REQ-022 Deasserting i_enable mid-frame SHALL NOT abort the current frame; it only blocks the next pop.
REQ-023 A change of i_fifo_data or i_fifo_empty after the pop SHALL NOT affect the frame in flight.
REQ-024 The bit-period counter SHALL be 16 bits wide, count 0..CLKS_PER_BIT-1, and reset to 0 on every state change.

Reset
REQ-025 Asserting i_reset_n=0 SHALL immediately force state=IDLE, o_tx=1, o_busy=0, o_done=0, o_fifo_rd=0, counter=0, bit index=0 and shift register=8'h00, including mid-frame.
REQ-026 The first pop after reset release SHALL occur no earlier than the first rising edge at which i_reset_n=1.

Structure
REQ-027 The state encoding and the CLKS_PER_BIT/PARITY_EN defaults SHALL live in the shared package fifo_uart_pkg.
REQ-028 The bit-period counter SHALL be a sub-module named baud_counter (inputs: clear, enable; output: one-cycle end-of-period tick).

Verification
REQ-029 CLKS_PER_BIT=4, PARITY_EN=0, FIFO holding 8'hA5 -> one o_fifo_rd pulse; o_tx = 0,1,0,1,0,0,1,0,1,1 (4 cycles per bit); o_done high in cycle 40 after the pop.
REQ-030 Same byte with PARITY_EN=1 -> parity bit 0 inserted before stop; o_done in cycle 44.
REQ-031 FIFO holding 8'h00 then 8'hFF, i_enable=1 -> two pops 41 cycles apart; the second frame's data bits are all 1.
REQ-032 i_fifo_empty=1 for 100 cycles with i_enable=1 -> o_fifo_rd never asserted; o_tx=1 and o_busy=0 throughout.
REQ-033 i_reset_n pulled low during data bit 3 -> o_tx=1 and o_busy=0 without waiting for a clock edge; no o_done pulse; the next pop occurs only after release.
REQ-034 i_enable dropped during START with 2 bytes queued -> the current frame completes with o_done; no further pop until i_enable=1.
